// File: rtl/register_file.sv
// register_file: 32 x WIDTH LEGv8 general-purpose register file.
// Two combinational read ports feeding the ALU operands, one synchronous
// write port taking the write-back value, X31 (XZR) reads as zero and has
// no storage. Optional same-cycle write-to-read bypass.
module register_file #(
   parameter int WIDTH  = 64,
   parameter bit BYPASS = 1'b1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [4:0]       RA,
   input  logic [4:0]       RB,
   input  logic [4:0]       RW,
   input  logic             RegWr,
   input  logic [WIDTH-1:0] BusW,
   output logic [WIDTH-1:0] BusA,
   output logic [WIDTH-1:0] BusB
);

   // Only X0..X30 have storage; X31 is the zero register.
   logic [WIDTH-1:0] regFile [0:30];

   // Read path for one port. Each entry is selected by an exact address
   // match, so address 31 falls through to the zero default. The bypass
   // overrides stored data only for a real register being written now.
   function automatic logic [WIDTH-1:0] readPort(
      input logic [4:0] addr,
      input logic       wrEn,
      input logic [4:0] wrAddr,
      input logic [WIDTH-1:0] wrData
   );
      logic [WIDTH-1:0] value;
      value = '0;
      for (int i = 0; i < 31; i++) begin
         if (addr == 5'(i)) begin
            value = regFile[i];
         end
      end
      if (BYPASS && wrEn && (wrAddr == addr) && (addr != 5'd31)) begin
         value = wrData;
      end
      return value;
   endfunction

   // Write port: reset clears every register and discards any write in
   // the same cycle. Otherwise each entry compares its own index against
   // RW, so at most the addressed entry can ever be loaded and a write to
   // X31 matches nothing.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < 31; i++) begin
            regFile[i] <= '0;
         end
      end else if (RegWr) begin
         for (int i = 0; i < 31; i++) begin
            if (RW == 5'(i)) begin
               regFile[i] <= BusW;
            end
         end
      end
   end

   // Port A: forced to zero while reset is held, independent of RA.
   always_comb begin
      BusA = '0;
      if (!Reset) begin
         BusA = readPort(RA, RegWr, RW, BusW);
      end
   end

   // Port B: same rules as port A, evaluated independently.
   always_comb begin
      BusB = '0;
      if (!Reset) begin
         BusB = readPort(RB, RegWr, RW, BusW);
      end
   end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed checks of register_file, with one instance
// built with the bypass and one without, both driven by the same inputs.
module tb_register_file;

   localparam int WIDTH = 64;

   logic             Clk;
   logic             Reset;
   logic [4:0]       RA;
   logic [4:0]       RB;
   logic [4:0]       RW;
   logic             RegWr;
   logic [WIDTH-1:0] BusW;
   logic [WIDTH-1:0] busAByp;
   logic [WIDTH-1:0] busBByp;
   logic [WIDTH-1:0] busANoByp;
   logic [WIDTH-1:0] busBNoByp;

   int compareCount;
   int mismatchCount;

   register_file #(.WIDTH(WIDTH), .BYPASS(1'b1)) dutByp (
      .Clk(Clk), .Reset(Reset), .RA(RA), .RB(RB), .RW(RW),
      .RegWr(RegWr), .BusW(BusW), .BusA(busAByp), .BusB(busBByp)
   );

   register_file #(.WIDTH(WIDTH), .BYPASS(1'b0)) dutNoByp (
      .Clk(Clk), .Reset(Reset), .RA(RA), .RB(RB), .RW(RW),
      .RegWr(RegWr), .BusW(BusW), .BusA(busANoByp), .BusB(busBNoByp)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Drive all inputs, then let the combinational read paths settle.
   task automatic applyStimulus(input logic rst, input logic wr,
                                input logic [4:0] rw, input logic [WIDTH-1:0] w,
                                input logic [4:0] ra, input logic [4:0] rb);
      Reset = rst;
      RegWr = wr;
      RW    = rw;
      BusW  = w;
      RA    = ra;
      RB    = rb;
      #1;
   endtask

   // Advance past the next rising edge, sampling well away from it.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Single comparison point: counts and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                              input logic [WIDTH-1:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Check all four read outputs against the per-variant expectations.
   task automatic checkAll(input string tag,
                           input logic [WIDTH-1:0] expAByp, input logic [WIDTH-1:0] expBByp,
                           input logic [WIDTH-1:0] expANoByp, input logic [WIDTH-1:0] expBNoByp);
      checkOutput({tag, " A byp"},   busAByp,   expAByp);
      checkOutput({tag, " B byp"},   busBByp,   expBByp);
      checkOutput({tag, " A nobyp"}, busANoByp, expANoByp);
      checkOutput({tag, " B nobyp"}, busBNoByp, expBNoByp);
   endtask

   initial begin
      compareCount  = 0;
      mismatchCount = 0;

      // Reset held two cycles; outputs forced to zero even with a write pending.
      applyStimulus(1'b1, 1'b1, 5'd4, 64'h1234, 5'd4, 5'd4);
      checkAll("reset hold", '0, '0, '0, '0);
      tick();
      tick();
      applyStimulus(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0);
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b0, 1'b0, 5'd0, '0, 5'(i), 5'(31 - i));
         checkAll($sformatf("post reset r%0d", i), '0, '0, '0, '0);
      end

      // Write requested during reset is discarded.
      applyStimulus(1'b1, 1'b1, 5'd5, 64'hAA, 5'd5, 5'd5);
      checkAll("reset with write", '0, '0, '0, '0);
      tick();
      applyStimulus(1'b0, 1'b0, 5'd0, '0, 5'd5, 5'd5);
      checkAll("x5 after reset write", '0, '0, '0, '0);

      // Two plain writes, then read both back on separate ports.
      applyStimulus(1'b0, 1'b1, 5'd1, 64'h0123_4567_89AB_CDEF, 5'd0, 5'd0);
      tick();
      applyStimulus(1'b0, 1'b1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 5'd0, '0, 5'd1, 5'd2);
      checkAll("x1 x2 readback", 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF);

      // Top real register boundary.
      applyStimulus(1'b0, 1'b1, 5'd30, 64'h8000_0000_0000_0001, 5'd1, 5'd1);
      checkAll("x30 write other read", 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF,
               64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
      tick();
      applyStimulus(1'b0, 1'b0, 5'd0, '0, 5'd30, 5'd2);
      checkAll("x30 readback", 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF);

      // XZR: write dropped, reads zero during and after.
      applyStimulus(1'b0, 1'b1, 5'd31, 64'hDEAD, 5'd31, 5'd31);
      checkAll("xzr during write", '0, '0, '0, '0);
      tick();
      checkAll("xzr next cycle", '0, '0, '0, '0);
      applyStimulus(1'b0, 1'b0, 5'd0, '0, 5'd31, 5'd31);
      checkAll("xzr idle", '0, '0, '0, '0);

      // Same-cycle read of the register being written.
      applyStimulus(1'b0, 1'b1, 5'd3, 64'h10, 5'd0, 5'd0);
      tick();
      applyStimulus(1'b0, 1'b1, 5'd3, 64'h20, 5'd3, 5'd3);
      checkAll("x3 same cycle", 64'h20, 64'h20, 64'h10, 64'h10);
      tick();
      applyStimulus(1'b0, 1'b0, 5'd0, '0, 5'd3, 5'd3);
      checkAll("x3 after edge", 64'h20, 64'h20, 64'h20, 64'h20);

      // Reset mid-sequence wipes contents; later writes work normally.
      applyStimulus(1'b0, 1'b1, 5'd7, 64'h55, 5'd0, 5'd0);
      tick();
      applyStimulus(1'b0, 1'b1, 5'd8, 64'h66, 5'd7, 5'd0);
      checkAll("x7 before reset", 64'h55, '0, 64'h55, '0);
      tick();
      applyStimulus(1'b1, 1'b0, 5'd0, '0, 5'd7, 5'd8);
      tick();
      applyStimulus(1'b0, 1'b0, 5'd0, '0, 5'd7, 5'd8);
      checkAll("x7 x8 after reset", '0, '0, '0, '0);
      applyStimulus(1'b0, 1'b1, 5'd7, 64'h77, 5'd0, 5'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 5'd0, '0, 5'd7, 5'd1);
      checkAll("x7 rewrite", 64'h77, '0, 64'h77, '0);

      // Back-to-back writes to X9 with both read ports watching.
      applyStimulus(1'b0, 1'b1, 5'd9, 64'd1, 5'd9, 5'd7);
      checkAll("x9 wr1", 64'd1, 64'h77, 64'd0, 64'h77);
      tick();
      applyStimulus(1'b0, 1'b1, 5'd9, 64'd2, 5'd9, 5'd7);
      checkAll("x9 wr2", 64'd2, 64'h77, 64'd1, 64'h77);
      tick();
      applyStimulus(1'b0, 1'b1, 5'd9, 64'd3, 5'd9, 5'd3);
      checkAll("x9 wr3", 64'd3, '0, 64'd2, '0);
      tick();
      applyStimulus(1'b0, 1'b0, 5'd0, '0, 5'd9, 5'd8);
      checkAll("x9 final", 64'd3, '0, 64'd3, '0);
      applyStimulus(1'b0, 1'b0, 5'd0, '0, 5'd10, 5'd2);
      checkAll("x10 x2 untouched", '0, '0, '0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
